// File: rtl/tdnn_input_assembler_if.sv
// Sample-in / feature-vector-out bus of the TDNN input assembler.
//   master : upstream side (drives samples, flush and gen_busy, observes vector)
//   slave  : the assembler itself
// Signals: flush, s_i, s_q, s_valid, s_ready, gen_busy, out_vector, out_valid, sat_flag
interface tdnn_input_assembler_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned INPUT_DIM  = 22
);
    logic                               flush;
    logic signed [DATA_WIDTH-1:0]       s_i;
    logic signed [DATA_WIDTH-1:0]       s_q;
    logic                               s_valid;
    logic                               s_ready;
    logic                               gen_busy;
    logic [DATA_WIDTH*INPUT_DIM-1:0]    out_vector;
    logic                               out_valid;
    logic                               sat_flag;

    modport master (
        output flush, s_i, s_q, s_valid, gen_busy,
        input  s_ready, out_vector, out_valid, sat_flag
    );

    modport slave (
        input  flush, s_i, s_q, s_valid, gen_busy,
        output s_ready, out_vector, out_valid, sat_flag
    );
endinterface

// File: rtl/tdnn_input_assembler.sv
// TDNN input assembler: takes one complex Q1.15 sample per handshake, keeps an
// M-deep I/Q history plus an M-deep envelope history (|x|, |x|^2) and presents
// the packed feature vector with a valid that holds until the generator takes it.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       flush, s_i/s_q/s_valid/s_ready sample handshake,
//                     gen_busy, out_vector/out_valid, sticky sat_flag
// Optional feature: define TDNN_PRIMING_EN to suppress out_valid until
// MEMORY_DEPTH samples have been accepted since reset/flush.
module tdnn_input_assembler #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned MEMORY_DEPTH = 5,
    parameter int unsigned INPUT_DIM    = 2 + 2 * MEMORY_DEPTH * 2
) (
    input logic                   clk,
    input logic                   rst_n,
    tdnn_input_assembler_if.slave bus
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned M  = MEMORY_DEPTH;
    localparam int unsigned PW = 2 * DW;       // single square
    localparam int unsigned SW = 2 * DW + 1;   // sum of squares
    localparam int unsigned MW = DW + 2;       // magnitude estimate
    localparam int unsigned VW = DW * INPUT_DIM;

    localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic        [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};

    // Stage 1: registered sample and its raw magnitude terms
    logic                 st1_v;
    logic signed [DW-1:0] st1_i, st1_q;
    logic        [DW-1:0] st1_abs_i, st1_abs_q;
    logic signed [PW-1:0] st1_sq_i, st1_sq_q;
    logic                 st1_sat;

    // Stage 2: newest sample, I/Q history and envelope history
    logic                 st2_v;
    logic signed [DW-1:0] cur_i, cur_q;
    logic signed [DW-1:0] hist_i [M];
    logic signed [DW-1:0] hist_q [M];
    logic        [DW-1:0] mag_h  [M];
    logic        [DW-1:0] pow_h  [M];
    logic                 sat_q;

    // Output register
    logic [VW-1:0]        out_vector_q;
    logic                 out_valid_q;

    logic                 s_ready_c;
    logic                 accept_c;
    logic                 emit_c;

    // Absolute value with the single overflow case clipped to full scale
    function automatic logic [DW-1:0] sat_abs(input logic signed [DW-1:0] x);
        logic [DW-1:0] r;
        if (x == S_MIN) begin
            r = S_MAX;
        end else if (x < 0) begin
            r = DW'(-x);
        end else begin
            r = DW'(x);
        end
        return r;
    endfunction

    // At most one sample in flight; flush drops a same-cycle offer
    assign s_ready_c = rst_n & ~(bus.flush | st1_v | st2_v | out_valid_q);
    assign accept_c  = bus.s_valid & s_ready_c;

    assign bus.s_ready    = s_ready_c;
    assign bus.out_vector = out_vector_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.sat_flag   = sat_q;

    // Envelope features from stage 1
    logic [DW-1:0]        mx_c, mn_c;
    logic [MW-1:0]        mag_w_c;
    logic signed [SW-1:0] pow_w_c;
    logic [DW-1:0]        mag_c, pow_c;
    logic                 mag_sat_c, pow_sat_c;

    always_comb begin
        mx_c = st1_abs_i;
        mn_c = st1_abs_q;
        if (st1_abs_q > st1_abs_i) begin
            mx_c = st1_abs_q;
            mn_c = st1_abs_i;
        end
        // |x| ~= max + min/4 + min/8
        mag_w_c   = MW'(mx_c) + MW'(mn_c >> 2) + MW'(mn_c >> 3);
        mag_sat_c = (mag_w_c[MW-1:DW-1] != '0);
        mag_c     = mag_sat_c ? S_MAX : mag_w_c[DW-1:0];
        // Sum is non-negative, so any bit at or above DW-1 means > full scale
        pow_w_c   = (SW'(st1_sq_i) + SW'(st1_sq_q)) >>> (DW - 1);
        pow_sat_c = (pow_w_c[SW-1:DW-1] != '0);
        pow_c     = pow_sat_c ? S_MAX : pow_w_c[DW-1:0];
    end

    // Packed vector from the stage-2 state
    logic [VW-1:0] vec_c;

    always_comb begin
        vec_c = '0;
        vec_c[0 +: DW]  = cur_i;
        vec_c[DW +: DW] = cur_q;
        for (int unsigned k = 0; k < M; k++) begin
            vec_c[DW*(2+2*k) +: DW]     = hist_i[k];
            vec_c[DW*(3+2*k) +: DW]     = hist_q[k];
            vec_c[DW*(2+2*M+2*k) +: DW] = mag_h[k];
            vec_c[DW*(3+2*M+2*k) +: DW] = pow_h[k];
        end
    end

`ifdef TDNN_PRIMING_EN
    localparam int unsigned PCW = 3;
    logic [PCW-1:0] prime_cnt;

    // Saturating count of accepts since reset/flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt <= '0;
        end else if (bus.flush) begin
            prime_cnt <= '0;
        end else if (accept_c && (prime_cnt != '1)) begin
            prime_cnt <= prime_cnt + PCW'(1);
        end
    end

    assign emit_c = (prime_cnt >= PCW'(M));
`else
    assign emit_c = 1'b1;
`endif

    // Pipeline, history and output registers; flush outranks everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st1_v        <= 1'b0;
            st1_i        <= '0;
            st1_q        <= '0;
            st1_abs_i    <= '0;
            st1_abs_q    <= '0;
            st1_sq_i     <= '0;
            st1_sq_q     <= '0;
            st1_sat      <= 1'b0;
            st2_v        <= 1'b0;
            cur_i        <= '0;
            cur_q        <= '0;
            sat_q        <= 1'b0;
            out_vector_q <= '0;
            out_valid_q  <= 1'b0;
            for (int unsigned k = 0; k < M; k++) begin
                hist_i[k] <= '0;
                hist_q[k] <= '0;
                mag_h[k]  <= '0;
                pow_h[k]  <= '0;
            end
        end else if (bus.flush) begin
            st1_v        <= 1'b0;
            st2_v        <= 1'b0;
            cur_i        <= '0;
            cur_q        <= '0;
            sat_q        <= 1'b0;
            out_vector_q <= '0;
            out_valid_q  <= 1'b0;
            for (int unsigned k = 0; k < M; k++) begin
                hist_i[k] <= '0;
                hist_q[k] <= '0;
                mag_h[k]  <= '0;
                pow_h[k]  <= '0;
            end
        end else begin
            st1_v <= accept_c;
            if (accept_c) begin
                st1_i     <= bus.s_i;
                st1_q     <= bus.s_q;
                st1_abs_i <= sat_abs(bus.s_i);
                st1_abs_q <= sat_abs(bus.s_q);
                st1_sq_i  <= PW'(bus.s_i) * PW'(bus.s_i);
                st1_sq_q  <= PW'(bus.s_q) * PW'(bus.s_q);
                st1_sat   <= (bus.s_i == S_MIN) | (bus.s_q == S_MIN);
            end

            st2_v <= st1_v;
            if (st1_v) begin
                // cur_* holds the previous sample until this shift
                cur_i     <= st1_i;
                cur_q     <= st1_q;
                hist_i[0] <= cur_i;
                hist_q[0] <= cur_q;
                mag_h[0]  <= mag_c;
                pow_h[0]  <= pow_c;
                for (int unsigned k = 1; k < M; k++) begin
                    hist_i[k] <= hist_i[k-1];
                    hist_q[k] <= hist_q[k-1];
                    mag_h[k]  <= mag_h[k-1];
                    pow_h[k]  <= pow_h[k-1];
                end
                sat_q <= sat_q | st1_sat | mag_sat_c | pow_sat_c;
            end

            if (st2_v) begin
                out_vector_q <= vec_c;
                out_valid_q  <= emit_c;
            end else if (out_valid_q && !bus.gen_busy) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdnn_input_assembler.sv
// Self-checking bench for tdnn_input_assembler: directed scenarios plus
// randomized traffic compared against a sample-queue reference model.
module tb_tdnn_input_assembler;

    localparam int DW = 16;
    localparam int M  = 5;
    localparam int ID = 2 + 4 * M;
    localparam int VW = DW * ID;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    tdnn_input_assembler_if #(.DATA_WIDTH(DW), .INPUT_DIM(ID)) bus ();

    tdnn_input_assembler #(
        .DATA_WIDTH(DW), .MEMORY_DEPTH(M), .INPUT_DIM(ID)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: every sample accepted since reset/flush, newest last
    int          smp_i[$];
    int          smp_q[$];
    bit          sat_exp;
    logic [VW-1:0] last_vec;

    function automatic int to_s(logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int clip_abs(int v);
        int a = (v < 0) ? -v : v;
        return (a > 32767) ? 32767 : a;
    endfunction

    function automatic int raw_mag(int si, int sq);
        int ai = clip_abs(si);
        int aq = clip_abs(sq);
        int mx = (ai > aq) ? ai : aq;
        int mn = (ai > aq) ? aq : ai;
        return mx + mn / 4 + mn / 8;
    endfunction

    function automatic longint raw_pow(int si, int sq);
        return (longint'(si) * si + longint'(sq) * sq) / 32768;
    endfunction

    function automatic bit mdl_sat(int si, int sq);
        return (si == -32768) || (sq == -32768) ||
               (raw_mag(si, sq) > 32767) || (raw_pow(si, sq) > 32767);
    endfunction

    function automatic logic [VW-1:0] build_exp();
        logic [VW-1:0] v = '0;
        int n = smp_i.size();
        for (int k = 0; k <= M; k++) begin
            int idx = n - 1 - k;
            if (idx >= 0) begin
                v[DW*(2*k) +: DW]   = 16'(smp_i[idx]);
                v[DW*(2*k+1) +: DW] = 16'(smp_q[idx]);
            end
        end
        for (int k = 0; k < M; k++) begin
            int idx = n - 1 - k;
            if (idx >= 0) begin
                int     m = raw_mag(smp_i[idx], smp_q[idx]);
                longint p = raw_pow(smp_i[idx], smp_q[idx]);
                v[DW*(2+2*M+2*k) +: DW] = (m > 32767) ? 16'h7FFF : 16'(m);
                v[DW*(3+2*M+2*k) +: DW] = (p > 32767) ? 16'h7FFF : 16'(p);
            end
        end
        return v;
    endfunction

    function automatic logic [15:0] el(logic [VW-1:0] v, int e);
        return v[DW*e +: DW];
    endfunction

    // One sample through the block; hold = cycles gen_busy stays high after out_valid
    task automatic do_txn(input logic [15:0] i, input logic [15:0] q, input int hold);
        int n = 0;
        bit emit;
        bit bad_v = 0, bad_d = 0, bad_r = 0;
        logic [VW-1:0] exp_v;
        @(negedge clk);
        while (bus.s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (bus.s_ready !== 1'b1) $display("FAIL ready_wait: s_ready=%b expected 1", bus.s_ready);
        else pass_cnt++;
        bus.gen_busy = (hold > 0);
        bus.s_i      = i;
        bus.s_q      = q;
        bus.s_valid  = 1'b1;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        smp_i.push_back(to_s(i));
        smp_q.push_back(to_s(q));
        if (mdl_sat(to_s(i), to_s(q))) sat_exp = 1'b1;
        exp_v = build_exp();
`ifdef TDNN_PRIMING_EN
        emit = (smp_i.size() >= M);
`else
        emit = 1'b1;
`endif
        @(posedge clk); #1;
        chk_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL early_valid: out_valid=%b expected 0", bus.out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (bus.out_valid !== emit) $display("FAIL valid_latency: out_valid=%b expected %b", bus.out_valid, emit);
        else pass_cnt++;
        chk_cnt++;
        if (bus.sat_flag !== sat_exp) $display("FAIL sat_flag: got %b expected %b", bus.sat_flag, sat_exp);
        else pass_cnt++;
        if (emit) begin
            chk_cnt++;
            if (bus.out_vector !== exp_v)
                $display("FAIL vector: got %h expected %h", bus.out_vector, exp_v);
            else pass_cnt++;
            last_vec = bus.out_vector;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                if (bus.out_valid !== 1'b1) bad_v = 1'b1;
                if (bus.out_vector !== exp_v) bad_d = 1'b1;
                if (bus.s_ready !== 1'b0) bad_r = 1'b1;
            end
            if (hold > 0) begin
                chk_cnt++;
                if (bad_v) $display("FAIL busy_valid: out_valid dropped while busy, expected held 1");
                else pass_cnt++;
                chk_cnt++;
                if (bad_d) $display("FAIL busy_vector: out_vector changed while busy, expected %h", exp_v);
                else pass_cnt++;
                chk_cnt++;
                if (bad_r) $display("FAIL busy_ready: s_ready rose while busy, expected 0");
                else pass_cnt++;
            end
            @(negedge clk);
            bus.gen_busy = 1'b0;
            @(posedge clk); #1;
            chk_cnt++;
            if (bus.out_valid !== 1'b0) $display("FAIL consume_fall: out_valid=%b expected 0", bus.out_valid);
            else pass_cnt++;
            chk_cnt++;
            if (bus.s_ready !== 1'b1) $display("FAIL ready_return: s_ready=%b expected 1", bus.s_ready);
            else pass_cnt++;
        end else begin
            @(negedge clk);
            bus.gen_busy = 1'b0;
            @(posedge clk); #1;
            chk_cnt++;
            if (bus.out_valid !== 1'b0) $display("FAIL primed_quiet: out_valid=%b expected 0", bus.out_valid);
            else pass_cnt++;
            chk_cnt++;
            if (bus.s_ready !== 1'b1) $display("FAIL primed_ready: s_ready=%b expected 1", bus.s_ready);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.s_i      = '0;
        bus.s_q      = '0;
        bus.s_valid  = 1'b0;
        bus.gen_busy = 1'b0;
        sat_exp      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (bus.out_vector !== '0) $display("FAIL reset_vector: got %h expected 0", bus.out_vector);
        else pass_cnt++;
        chk_cnt++;
        if (bus.sat_flag !== 1'b0) $display("FAIL reset_sat: got %b expected 0", bus.sat_flag);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cnt++;
        if (bus.s_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.s_ready);
        else pass_cnt++;
    endtask

    task automatic test_single();
        do_txn(16'h4000, 16'h0000, 0);
`ifndef TDNN_PRIMING_EN
        chk_cnt++;
        if (el(last_vec, 0) !== 16'h4000) $display("FAIL single_e0: got %h expected 4000", el(last_vec, 0));
        else pass_cnt++;
        chk_cnt++;
        if (el(last_vec, 12) !== 16'h4000) $display("FAIL single_e12: got %h expected 4000", el(last_vec, 12));
        else pass_cnt++;
        chk_cnt++;
        if (el(last_vec, 13) !== 16'h2000) $display("FAIL single_e13: got %h expected 2000", el(last_vec, 13));
        else pass_cnt++;
        chk_cnt++;
        if (el(last_vec, 2) !== 16'h0000) $display("FAIL single_tap: got %h expected 0", el(last_vec, 2));
        else pass_cnt++;
`endif
    endtask

    task automatic test_history();
        logic [15:0] ev [6];
        for (int k = 1; k <= 7; k++) do_txn(16'(k), 16'(-k), 0);
        ev = '{16'h0007, 16'hFFF9, 16'h0006, 16'hFFFA, 16'h0002, 16'hFFFE};
        chk_cnt++;
        if (el(last_vec, 0) !== ev[0]) $display("FAIL hist_e0: got %h expected %h", el(last_vec, 0), ev[0]);
        else pass_cnt++;
        chk_cnt++;
        if (el(last_vec, 1) !== ev[1]) $display("FAIL hist_e1: got %h expected %h", el(last_vec, 1), ev[1]);
        else pass_cnt++;
        chk_cnt++;
        if (el(last_vec, 2) !== ev[2]) $display("FAIL hist_e2: got %h expected %h", el(last_vec, 2), ev[2]);
        else pass_cnt++;
        chk_cnt++;
        if (el(last_vec, 3) !== ev[3]) $display("FAIL hist_e3: got %h expected %h", el(last_vec, 3), ev[3]);
        else pass_cnt++;
        chk_cnt++;
        if (el(last_vec, 10) !== ev[4]) $display("FAIL hist_e10: got %h expected %h", el(last_vec, 10), ev[4]);
        else pass_cnt++;
        chk_cnt++;
        if (el(last_vec, 11) !== ev[5]) $display("FAIL hist_e11: got %h expected %h", el(last_vec, 11), ev[5]);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_txn(16'h8000, 16'h8000, 0);
        chk_cnt++;
        if (el(last_vec, 12) !== 16'h7FFF) $display("FAIL sat_mag: got %h expected 7fff", el(last_vec, 12));
        else pass_cnt++;
        chk_cnt++;
        if (el(last_vec, 13) !== 16'h7FFF) $display("FAIL sat_pow: got %h expected 7fff", el(last_vec, 13));
        else pass_cnt++;
        do_txn(16'h0100, 16'h0100, 0);
    endtask

    task automatic test_busy_hold();
        do_txn(16'h1234, 16'hEDCC, 50);
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        @(negedge clk);
        bus.s_i     = 16'h2222;
        bus.s_q     = 16'h1111;
        bus.s_valid = 1'b1;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        smp_i.delete();
        smp_q.delete();
        sat_exp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (bus.out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk_cnt++;
        if (seen) $display("FAIL flush_valid: out_valid rose after flush, expected 0");
        else pass_cnt++;
        chk_cnt++;
        if (bus.sat_flag !== 1'b0) $display("FAIL flush_sat: got %b expected 0", bus.sat_flag);
        else pass_cnt++;
        // Offer coinciding with flush is refused
        @(negedge clk);
        bus.flush   = 1'b1;
        bus.s_i     = 16'h3333;
        bus.s_q     = 16'h3333;
        bus.s_valid = 1'b1;
        #1;
        chk_cnt++;
        if (bus.s_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", bus.s_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        bus.flush   = 1'b0;
        bus.s_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        chk_cnt++;
        if (seen) $display("FAIL flush_drop: dropped sample produced out_valid, expected none");
        else pass_cnt++;
        do_txn(16'h1234, 16'h0567, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [15:0] ri, rq;
            int r = $urandom_range(0, 7);
            ri = 16'($urandom);
            rq = 16'($urandom);
            if (r == 0) ri = 16'h8000;
            if (r == 1) rq = 16'h7FFF;
            if (r == 2) begin
                ri = 16'h7FFF;
                rq = 16'h8001;
            end
            do_txn(ri, rq, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        do_txn(16'h1000, 16'h2000, 0);
        @(negedge clk);
        bus.s_i     = 16'h8000;
        bus.s_q     = 16'h8000;
        bus.s_valid = 1'b1;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        chk_cnt++;
        if (bus.sat_flag !== 1'b1) $display("FAIL mid_sat_pre: got %b expected 1", bus.sat_flag);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (bus.out_vector !== '0) $display("FAIL mid_vector: got %h expected 0", bus.out_vector);
        else pass_cnt++;
        chk_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL mid_valid: got %b expected 0", bus.out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (bus.sat_flag !== 1'b0) $display("FAIL mid_sat: got %b expected 0", bus.sat_flag);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        smp_i.delete();
        smp_q.delete();
        sat_exp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        chk_cnt++;
        if (seen) $display("FAIL mid_discard: in-flight sample produced out_valid, expected none");
        else pass_cnt++;
        chk_cnt++;
        if (bus.s_ready !== 1'b1) $display("FAIL mid_ready: got %b expected 1", bus.s_ready);
        else pass_cnt++;
        do_txn(16'h0800, 16'hF800, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_history();
        test_saturation();
        test_busy_hold();
        test_flush();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
